tone_player: RTL and testbench

Melody sequencer and square-wave generator for the Basys3 audio path. On a one-cycle `start` pulse it plays a fixed four-note arpeggio (C5-E5-G5-C6) on `audio_out` and drives the PAM8302-style amplifier controls `amp_gain` and `amp_shdn`. It sits downstream of the game-state logic, which pulses `start` on a solve event. Its outputs go straight to Pmod JA1-JA3.

---
 rtl/tone_player_if.sv | 35 +++
 rtl/tone_player.sv | 132 +++++++++++++
 tb/tb_tone_player.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tone_player_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tone_player_if : control/status bundle between game logic and     |
// | the tone player.                              Revision 1.0        |
// +------------------------------------------------------------------+
interface tone_player_if;
  logic enable;
  logic start;
  logic audio_out;
  logic amp_gain;
  logic amp_shdn;
  logic busy;
  logic done;

  modport master (
    output enable,
    output start,
    input  audio_out,
    input  amp_gain,
    input  amp_shdn,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  start,
    output audio_out,
    output amp_gain,
    output amp_shdn,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/tone_player.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tone_player : four-note arpeggio sequencer and square-wave tone   |
// | generator driving a small class-D amplifier.  Revision 1.0        |
// +------------------------------------------------------------------+
module tone_player #(
  parameter int NOTE_CYC = 20_000_000,
  parameter int GAP_CYC  = 2_000_000,
  parameter int TONE_DIV = 1,
  parameter bit GAIN_HI  = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  tone_player_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [24:0] NOTE_LAST = 25'(NOTE_CYC - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_CYC - 1);

  // Half-periods of C5, E5, G5, C6 in clk cycles at 100 MHz.
  localparam logic [16:0] HALF0 = 17'(95602 / TONE_DIV);
  localparam logic [16:0] HALF1 = 17'(75873 / TONE_DIV);
  localparam logic [16:0] HALF2 = 17'(63776 / TONE_DIV);
  localparam logic [16:0] HALF3 = 17'(47755 / TONE_DIV);

  state_t      state;
  logic [1:0]  note_idx;
  logic [16:0] tone_cnt;
  logic [24:0] dur_cnt;
  logic        tone_level;
  logic        busy_flag;
  logic        done_flag;
  logic [16:0] half_last;

  always_comb begin
    half_last = HALF0 - 17'd1;
    case (note_idx)
      2'd0: half_last = HALF0 - 17'd1;
      2'd1: half_last = HALF1 - 17'd1;
      2'd2: half_last = HALF2 - 17'd1;
      2'd3: half_last = HALF3 - 17'd1;
      default: half_last = HALF0 - 17'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      note_idx   <= 2'd0;
      tone_cnt   <= 17'd0;
      dur_cnt    <= 25'd0;
      tone_level <= 1'b0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      // Disable overrides start and any terminal count in the same cycle.
      if (!bus.enable) begin
        state      <= IDLE;
        note_idx   <= 2'd0;
        tone_cnt   <= 17'd0;
        dur_cnt    <= 25'd0;
        tone_level <= 1'b0;
        busy_flag  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state      <= PLAY;
              note_idx   <= 2'd0;
              tone_cnt   <= 17'd0;
              dur_cnt    <= 25'd0;
              tone_level <= 1'b0;
              busy_flag  <= 1'b1;
            end
          end
          PLAY: begin
            if (dur_cnt == NOTE_LAST) begin
              state      <= GAP;
              tone_cnt   <= 17'd0;
              dur_cnt    <= 25'd0;
              tone_level <= 1'b0;
            end else begin
              dur_cnt <= dur_cnt + 25'd1;
              if (tone_cnt == half_last) begin
                tone_cnt   <= 17'd0;
                tone_level <= ~tone_level;
              end else begin
                tone_cnt <= tone_cnt + 17'd1;
              end
            end
          end
          GAP: begin
            if (dur_cnt == GAP_LAST) begin
              dur_cnt  <= 25'd0;
              tone_cnt <= 17'd0;
              if (note_idx == 2'd3) begin
                state     <= IDLE;
                note_idx  <= 2'd0;
                busy_flag <= 1'b0;
                done_flag <= 1'b1;
              end else begin
                state    <= PLAY;
                note_idx <= note_idx + 2'd1;
              end
            end else begin
              dur_cnt <= dur_cnt + 25'd1;
            end
          end
          default: begin
            state     <= IDLE;
            busy_flag <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.audio_out = tone_level;
  assign bus.amp_shdn  = busy_flag;
  assign bus.busy      = busy_flag;
  assign bus.done      = done_flag;
  assign bus.amp_gain  = GAIN_HI;

endmodule
`default_nettype wire

// File: tb/tb_tone_player.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tone_player : directed self-checking bench for tone_player.    |
// |                                                 Revision 1.0      |
// +------------------------------------------------------------------+
module tb_tone_player;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  tone_player_if bus ();

  tone_player #(
    .NOTE_CYC(1000),
    .GAP_CYC (100),
    .TONE_DIV(1000),
    .GAIN_HI (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 ns after the edge that sampled start (cycle 0 of playback).
  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_melody(input bit inject, input string tag);
    int halfs[4];
    int rise_at[4];
    int wave_err[4];
    int gap_err, busy_cnt, done_cnt, done_pos, shdn_err;
    int n, w, exp;
    halfs = '{95, 75, 63, 47};
    rise_at = '{-1, -1, -1, -1};
    wave_err = '{0, 0, 0, 0};
    gap_err = 0; busy_cnt = 0; done_cnt = 0; done_pos = -1; shdn_err = 0;
    pulse_start();
    check({tag, "_start_busy"}, int'(bus.busy), 1);
    check({tag, "_start_shdn"}, int'(bus.amp_shdn), 1);
    check({tag, "_start_audio"}, int'(bus.audio_out), 0);
    for (int c = 0; c < 4410; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.amp_shdn != bus.busy) shdn_err++;
      if (bus.done) begin
        done_cnt++;
        done_pos = c;
      end
      if (c < 4400) begin
        n = c / 1100;
        w = c % 1100;
        if (w < 1000) begin
          exp = (w / halfs[n]) % 2;
          if (int'(bus.audio_out) != exp) wave_err[n]++;
          if (bus.audio_out && rise_at[n] < 0) rise_at[n] = w;
        end else if (bus.audio_out) begin
          gap_err++;
        end
      end else if (bus.audio_out) begin
        gap_err++;
      end
      bus.start = (inject && c == 1500);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_rise_note%0d", tag, i), rise_at[i], halfs[i]);
      check($sformatf("%s_wave_note%0d", tag, i), wave_err[i], 0);
    end
    check({tag, "_gap_silent"}, gap_err, 0);
    check({tag, "_busy_cycles"}, busy_cnt, 4400);
    check({tag, "_shdn_follows_busy"}, shdn_err, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_pos"}, done_pos, 4400);
  endtask

  initial begin
    int err_a, err_s, err_b, err_d, err_g, done_cnt, rise, found;
    n_checks = 0;
    n_fail   = 0;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset / idle hold
    err_a = 0; err_s = 0; err_b = 0; err_d = 0; err_g = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (bus.audio_out) err_a++;
      if (bus.amp_shdn)  err_s++;
      if (bus.busy)      err_b++;
      if (bus.done)      err_d++;
      if (!bus.amp_gain) err_g++;
    end
    check("idle_audio", err_a, 0);
    check("idle_shdn", err_s, 0);
    check("idle_busy", err_b, 0);
    check("idle_done", err_d, 0);
    check("idle_gain", err_g, 0);

    run_melody(1'b0, "full");
    run_melody(1'b1, "ignored_start");

    // Enable abort during note 2
    done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 2500; c++) begin
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
    end
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_shdn", int'(bus.amp_shdn), 0);
    check("abort_audio", int'(bus.audio_out), 0);
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    bus.enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Restart after abort must begin at note 0
    pulse_start();
    rise = -1;
    for (int c = 0; c < 200 && rise < 0; c++) begin
      if (bus.audio_out) rise = c;
      else begin
        @(posedge clk); #1;
      end
    end
    check("restart_rise_note0", rise, 95);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    bus.enable = 1'b1;

    // Start gated by enable=0
    bus.enable = 1'b0;
    pulse_start();
    err_b = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy) err_b++;
      @(posedge clk); #1;
    end
    check("gated_busy", err_b, 0);
    bus.enable = 1'b1;

    // Asynchronous reset mid-note while audio_out is high
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (bus.audio_out) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("async_audio_high_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_audio", int'(bus.audio_out), 0);
    check("async_shdn", int'(bus.amp_shdn), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_done", int'(bus.done), 0);
    check("async_gain", int'(bus.amp_gain), 1);
    err_a = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.audio_out || bus.amp_shdn || bus.busy || bus.done) err_a++;
    end
    check("async_hold", err_a, 0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_release_busy", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
